// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 bit-select mux: steps the select through the enabled
// channels, waits a programmable settle time on each, and assembles the sampled bits.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         ch_mask,
    output logic [2:0]         sel,
    input  logic               mux_y,
    output logic               busy,
    output logic               done,
    output logic [7:0]         result
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         shadow_q, shadow_d;
    logic [7:0]         result_q, result_d;
    logic [7:0]         above;
    logic [7:0]         merged;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest = 3'(i);
        end
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        result_d = result_q;

        above = '0;
        for (int i = 0; i < 8; i++) begin
            above[i] = mask_q[i] && (3'(i) > sel_q);
        end
        merged         = shadow_q;
        merged[sel_q]  = mux_y;

        case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (start) begin
                    dwell_d  = dwell;
                    mask_d   = ch_mask;
                    shadow_d = '0;
                    if (ch_mask == 8'h00) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        sel_d   = lowest(ch_mask);
                        cnt_d   = dwell;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - DWELL_W'(1);
            end
            SAMPLE: begin
                shadow_d = merged;
                if (|above) begin
                    sel_d   = lowest(above);
                    cnt_d   = dwell_q;
                    state_d = SETTLE;
                end else begin
                    // The final sample goes straight into the result, bypassing the shadow.
                    sel_d    = 3'd0;
                    result_d = merged;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
        end
    end

    assign sel    = sel_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: table-driven scans plus hand-written
// corner sequences, with a scoreboard queue matching each done pulse to its scan.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dwell = '0;
    logic [7:0] ch_mask = '0;
    logic [2:0] sel;
    logic       mux_y;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] data = '0;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        string      name;
        logic [7:0] mask;
        logic [3:0] dw;
        logic [7:0] data;
        logic [7:0] exp_res;
        int         exp_done;
    } vec_t;

    vec_t vecs[7];

    mux_scan_sequencer #(.DWELL_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dwell   (dwell),
        .ch_mask (ch_mask),
        .sel     (sel),
        .mux_y   (mux_y),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    assign mux_y = data[sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding scan.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [7:0] exp;
                exp = sb_q.pop_front();
                check("sb_result", 32'(result), 32'(exp));
            end
        end
    end

    task automatic run_scan(input string name, input logic [7:0] mask, input logic [3:0] dw,
                            input logic [7:0] d0, input logic [7:0] exp_res, input int exp_done,
                            input int s1, input int s2, input int chg_cyc, input logic [7:0] chg_data);
        logic [2:0] exp_sel [0:299];
        logic [7:0] seen;
        int c;
        bit got;
        c = 1;
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                for (int k = 0; k < 32'(dw) + 2; k++) begin
                    exp_sel[c] = 3'(ch);
                    c++;
                end
            end
        end
        @(posedge clk); #1;
        data = d0; ch_mask = mask; dwell = dw; start = 1'b1;
        sb_q.push_back(exp_res);
        @(negedge clk);
        check({name, "_busy_c0"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; ch_mask = ~mask; dwell = ~dw;
        c = 1; seen = '0; got = 1'b0;
        while (!got && c < 300) begin
            start = (c == s1 || c == s2);
            if (c == chg_cyc) data = chg_data;
            @(negedge clk);
            check({name, "_busy"}, 32'(busy), 32'd1);
            if (done === 1'b1) begin
                got = 1'b1;
                check({name, "_done_cycle"}, 32'(c), 32'(exp_done));
                check({name, "_sel_done"}, 32'(sel), 32'd0);
            end else begin
                check({name, "_sel"}, 32'(sel), 32'(exp_sel[c]));
                seen[sel] = 1'b1;
                @(posedge clk); #1;
                c++;
            end
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_channels_seen"}, 32'(seen), 32'(mask));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_result_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        vecs[0] = '{"all_ch_dw0",  8'hFF, 4'd0,  8'hA5, 8'hA5, 17};
        vecs[1] = '{"two_ch_dw3",  8'h42, 4'd3,  8'hFF, 8'h42, 11};
        vecs[2] = '{"empty_mask",  8'h00, 4'd5,  8'hFF, 8'h00, 1};
        vecs[3] = '{"upper_dw1",   8'hF0, 4'd1,  8'h3C, 8'h30, 13};
        vecs[4] = '{"max_dwell",   8'h81, 4'd15, 8'hDB, 8'h81, 35};
        vecs[5] = '{"ch7_only",    8'h80, 4'd0,  8'h80, 8'h80, 3};
        vecs[6] = '{"ch0_zero",    8'h01, 4'd2,  8'hFE, 8'h00, 5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_scan(vecs[i].name, vecs[i].mask, vecs[i].dw, vecs[i].data,
                     vecs[i].exp_res, vecs[i].exp_done, -1, -1, -1, 8'h00);
        end

        // start pulses mid-scan must be ignored, not queued
        run_scan("start_ignored", 8'hFF, 4'd0, 8'h5A, 8'h5A, 17, 3, 9, -1, 8'h00);

        // mux_y must be taken on the SAMPLE cycle only
        run_scan("late_rise", 8'h04, 4'd2, 8'h00, 8'h04, 5, -1, -1, 4, 8'h04);
        run_scan("late_fall", 8'h04, 4'd2, 8'h04, 8'h00, 5, -1, -1, 4, 8'h00);

        // establish a nonzero result, then reset mid-scan
        run_scan("pre_reset", 8'h81, 4'd0, 8'hFF, 8'h81, 5, -1, -1, -1, 8'h00);
        @(posedge clk); #1;
        data = 8'hA5; ch_mask = 8'hFF; dwell = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_mid_busy_c5", 32'(busy), 32'd1);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_sel", 32'(sel), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'd0);
        run_scan("after_reset", 8'hFF, 4'd0, 8'hA5, 8'hA5, 17, -1, -1, -1, 8'h00);

        // start held across DONE -> IDLE launches a new scan from the IDLE cycle
        @(posedge clk); #1;
        data = 8'h01; ch_mask = 8'h01; dwell = 4'd0; start = 1'b1;
        sb_q.push_back(8'h01);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                data = 8'h00;
                sb_q.push_back(8'h00);
            end
            if (c == 5) start = 1'b0;
            @(negedge clk);
            check($sformatf("held_start_done_c%0d", c), 32'(done), 32'((c == 3) || (c == 7)));
            check($sformatf("held_start_busy_c%0d", c), 32'(busy), 32'(!((c == 4) || (c == 8))));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
